// File: rtl/pic_pixel_streamer.sv
// Sweeps the picture RAM in raster order and streams pixels on a valid/ready
// interface tagged with row/col/last; a shift FIFO hides the RAM read latency.
module pic_pixel_streamer #(
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  input  logic          ram_valid,
  output logic [DW-1:0] pix_data,
  output logic [4:0]    pix_row,
  output logic [4:0]    pix_col,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_last
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned PW    = $clog2(NPIX + 1);
  // The RAM output register holds one read beyond the issue stage, so the
  // storage carries one extra slot to keep full throughput without overflow.
  localparam int unsigned SLOTS = FIFO_DEPTH + 1;
  localparam int unsigned CW    = $clog2(SLOTS + 1);
  localparam int unsigned OW    = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   issue_ptr;
  logic            inflight;
  logic            rd_pend;
  logic [CW-1:0]   count, count_d, wr_idx;
  logic [DW-1:0]   fifo_mem [SLOTS];
  logic [4:0]      row_d, col_d;
  logic            start_acc, issue, pop, push;
  logic [OW-1:0]   occ;

  // Next-state, issue decision and head-pixel tag update.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    issue     = 1'b0;
    pop       = pix_valid & pix_ready;
    push      = rd_pend;
    occ       = OW'(count) + OW'(inflight) + OW'(rd_pend) - OW'(pop);
    row_d     = pix_row;
    col_d     = pix_col;
    count_d   = count + CW'(push) - CW'(pop);
    wr_idx    = count - CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          issue     = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        issue = (issue_ptr < PW'(NPIX)) && (occ < OW'(SLOTS));
        if (pop && pix_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start_acc || (pop && pix_last)) begin
      row_d = 5'd0;
      col_d = 5'd0;
    end else if (pop) begin
      if (pix_col == 5'(IMG_W - 1)) begin
        col_d = 5'd0;
        row_d = pix_row + 5'd1;
      end else begin
        col_d = pix_col + 5'd1;
      end
    end
  end

  // Control, RAM interface and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      issue_ptr <= '0;
      inflight  <= 1'b0;
      rd_pend   <= 1'b0;
      ram_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= issue;
      rd_pend  <= inflight;
      busy     <= (state_d == S_RUN);
      done     <= (state_d == S_DONE);
      if (issue) begin
        ram_addr  <= start_acc ? '0 : AW'(issue_ptr);
        issue_ptr <= start_acc ? PW'(1) : issue_ptr + PW'(1);
      end
      if (start_acc)               err <= 1'b0;
      else if (push && !ram_valid) err <= 1'b1;
    end
  end

  // Shift FIFO: entry 0 is the head, so pix_data comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      pix_row   <= 5'd0;
      pix_col   <= 5'd0;
      for (int unsigned i = 0; i < SLOTS; i++) fifo_mem[i] <= '0;
    end else begin
      count     <= count_d;
      pix_valid <= (count_d != '0);
      pix_last  <= (count_d != '0) && (row_d == 5'(IMG_H - 1)) && (col_d == 5'(IMG_W - 1));
      pix_row   <= row_d;
      pix_col   <= col_d;
      if (pop) begin
        for (int unsigned i = 0; i + 1 < SLOTS; i++) fifo_mem[i] <= fifo_mem[i+1];
      end
      if (push) fifo_mem[wr_idx] <= ram_dout;
    end
  end

  assign pix_data = fifo_mem[0];

endmodule

// File: tb/tb_pic_pixel_streamer.sv
// Scoreboard bench for pic_pixel_streamer: a RAM model feeds the DUT, expected
// pixels are queued per sweep and a monitor checks every transfer.
module tb_pic_pixel_streamer;

  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic [9:0] ram_addr;
  logic [7:0] ram_dout = 8'd0;
  logic       ram_valid = 1'b1;
  logic [7:0] pix_data;
  logic [4:0] pix_row, pix_col;
  logic       pix_valid, pix_last;
  logic       pix_ready = 1'b1;

  logic [7:0] mem [1024];
  logic       bad_en = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] r;
    logic [4:0] c;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = -10;

  pic_pixel_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_valid(ram_valid),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Picture RAM model: one-cycle registered read, valid flag can be forced low at address 200.
  always @(posedge clk) begin
    ram_dout  <= mem[ram_addr];
    ram_valid <= !(bad_en && ram_addr == 10'd200);
  end

  // Monitor: every transfer pops one expected pixel; done must follow the last transfer by one cycle.
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer got d=%h r=%0d c=%0d", pix_data, pix_row, pix_col);
      end else begin
        mon_e = exp_q.pop_front();
        if (pix_data !== mon_e.d || pix_row !== mon_e.r || pix_col !== mon_e.c || pix_last !== mon_e.l) begin
          errors++;
          $display("FAIL pixel got d=%h r=%0d c=%0d l=%b exp d=%h r=%0d c=%0d l=%b",
                   pix_data, pix_row, pix_col, pix_last, mon_e.d, mon_e.r, mon_e.c, mon_e.l);
        end
      end
      if (pix_last) last_cyc = cyc;
    end
    if (!rst && done) begin
      checks++;
      if (cyc != last_cyc + 1 || exp_q.size() != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_timing got cyc=%0d left=%0d busy=%b exp cyc=%0d left=0 busy=0",
                 cyc, exp_q.size(), busy, last_cyc + 1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, expv);
    end
  endtask

  task automatic push_sweep();
    exp_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.d = mem[i];
      e.r = 5'(i / 28);
      e.c = 5'(i % 28);
      e.l = (i == NPIX - 1);
      exp_q.push_back(e);
    end
  endtask

  // Start is sampled at the second posedge of this task (E0); returns at E0+1.
  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_head(input int r, input int c);
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!(pix_valid && pix_row == 5'(r) && pix_col == 5'(c)) && k < 3000);
    if (k >= 3000) begin
      checks++; errors++;
      $display("FAIL wait_head timeout got r=%0d c=%0d exp r=%0d c=%0d", pix_row, pix_col, r, c);
    end
  endtask

  task automatic wait_done(input bit rnd);
    int k = 0;
    do begin
      @(posedge clk); #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk); k++;
    end while (!done && k < 5000);
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done timeout got done=0 exp done=1");
    end
    @(posedge clk); #1 pix_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_rowcol", {pix_row, pix_col}, 0);

    // 1: latency and full sweep with ready held high
    push_sweep();
    start_pulse();
    @(negedge clk);
    chk("lat_addr_e0", 32'(ram_addr), 0);
    chk("lat_busy_e0", 32'(busy), 1);
    chk("lat_valid_e0", 32'(pix_valid), 0);
    @(negedge clk);
    chk("lat_valid_e1", 32'(pix_valid), 0);
    @(negedge clk);
    chk("lat_valid_e2", 32'(pix_valid), 1);
    chk("lat_data_e2", 32'(pix_data), 32'(mem[0]));
    wait_done(1'b0);
    chk("t1_err", 32'(err), 0);

    // 2: stall five cycles with pixel 100 at the head
    push_sweep();
    start_pulse();
    wait_head(3, 15);
    @(posedge clk); #1 pix_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(pix_valid), 1);
      chk("stall_data", 32'(pix_data), 32'(mem[100]));
      chk("stall_rowcol", {pix_row, pix_col}, {5'd3, 5'd16});
      chk("stall_addr_le102", 32'(ram_addr <= 10'd102), 1);
    end
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_done(1'b0);

    // 3: pseudo-random backpressure over a full sweep
    push_sweep();
    start_pulse();
    wait_done(1'b1);
    chk("t3_err", 32'(err), 0);

    // 4: start during the sweep is ignored; a later start restarts at address 0
    push_sweep();
    start_pulse();
    wait_head(10, 20);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1'b0);
    push_sweep();
    start_pulse();
    @(negedge clk);
    chk("t4_restart_addr", 32'(ram_addr), 0);
    chk("t4_restart_busy", 32'(busy), 1);
    wait_done(1'b0);

    // 5: asynchronous reset with pixel 500 at the head
    push_sweep();
    start_pulse();
    wait_head(17, 24);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(pix_valid), 0);
    chk("arst_last", 32'(pix_last), 0);
    chk("arst_addr", 32'(ram_addr), 0);
    chk("arst_data", 32'(pix_data), 0);
    chk("arst_rowcol", {pix_row, pix_col}, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    push_sweep();
    start_pulse();
    wait_done(1'b0);

    // 6: ram_valid low on the read of address 200
    bad_en = 1'b1;
    push_sweep();
    start_pulse();
    wait_head(6, 22);
    chk("t6_err_before", 32'(err), 0);
    wait_done(1'b0);
    chk("t6_err_after", 32'(err), 1);
    bad_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 1);
    push_sweep();
    start_pulse();
    @(negedge clk);
    chk("t6_err_cleared", 32'(err), 0);
    wait_done(1'b0);
    chk("t6_err_final", 32'(err), 0);

    repeat (3) @(negedge clk);
    chk("end_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
